// File: rtl/coeff_recomposer.sv
// Rebuilds r = (r1*alpha + r0) mod q for LANES coefficient pairs per beat.
// Two-stage valid/ready pipeline with a single global enable.
module coeff_recomposer #(
  parameter int unsigned COEFF_W = 24,
  parameter int unsigned LANES   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [2:0]                 sec_lvl,
  input  logic                       valid_i,
  output logic                       ready_i,
  input  logic [COEFF_W*LANES-1:0]   dia,
  input  logic [COEFF_W*LANES-1:0]   dib,
  // named dout because 'do' is a reserved word
  output logic [COEFF_W*LANES-1:0]   dout,
  output logic                       valid_o,
  input  logic                       ready_o,
  output logic                       err_o
);

  localparam int unsigned DATA_W = COEFF_W * LANES;
  localparam int unsigned SUM_W  = COEFF_W + 1;

  localparam logic [COEFF_W-1:0] Q      = COEFF_W'(8380417);
  localparam logic [SUM_W-1:0]   Q_S    = SUM_W'(8380417);
  localparam logic [COEFF_W-1:0] LIM_N1 = COEFF_W'(43);
  localparam logic [COEFF_W-1:0] LIM_N2 = COEFF_W'(15);
  localparam logic [2:0]         SEC_N1 = 3'd2;

  logic                              en;
  logic                              sel_n1;
  logic [COEFF_W-1:0]                lim;
  logic [LANES-1:0][COEFF_W-1:0]     r1_w;
  logic [LANES-1:0][COEFF_W-1:0]     r0_w;
  logic [LANES-1:0][COEFF_W-1:0]     p_nxt;
  logic [LANES-1:0]                  err_nxt;
  logic [LANES-1:0][COEFF_W-1:0]     p_q;
  logic [LANES-1:0][COEFF_W-1:0]     r0_q;
  logic [LANES-1:0]                  err_q;
  logic                              v1;
  logic [LANES-1:0][SUM_W-1:0]       s_w;
  logic [LANES-1:0][COEFF_W-1:0]     d_nxt;
  logic [DATA_W-1:0]                 d_flat;

  assign en      = !valid_o || ready_o;
  assign ready_i = en;
  assign sel_n1  = (sec_lvl == SEC_N1);
  assign lim     = sel_n1 ? LIM_N1 : LIM_N2;
  assign r1_w    = dia;
  assign r0_w    = dib;
  assign d_flat  = d_nxt;

  // Stage 1: constant multiply as shift-add (N1 = 2^17+2^15+2^14+2^13+2^11, N2 = 2^19-2^9)
  always_comb begin : stage1_comb
    p_nxt   = '0;
    err_nxt = '0;
    for (int k = 0; k < LANES; k++) begin
      if (sel_n1) begin
        p_nxt[k] = (r1_w[k] << 17) + (r1_w[k] << 15) + (r1_w[k] << 14)
                 + (r1_w[k] << 13) + (r1_w[k] << 11);
      end else begin
        p_nxt[k] = (r1_w[k] << 19) - (r1_w[k] << 9);
      end
      err_nxt[k] = (r1_w[k] > lim) || (r0_w[k] >= Q);
    end
  end

  // Stage 2: add r0 and fold once into [0, q-1]
  always_comb begin : stage2_comb
    s_w   = '0;
    d_nxt = '0;
    for (int k = 0; k < LANES; k++) begin
      s_w[k]   = SUM_W'(p_q[k]) + SUM_W'(r0_q[k]);
      d_nxt[k] = (s_w[k] >= Q_S) ? COEFF_W'(s_w[k] - Q_S) : COEFF_W'(s_w[k]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_q     <= '0;
      r0_q    <= '0;
      err_q   <= '0;
      v1      <= 1'b0;
      dout    <= '0;
      err_o   <= 1'b0;
      valid_o <= 1'b0;
    end else if (en) begin
      p_q     <= p_nxt;
      r0_q    <= r0_w;
      err_q   <= err_nxt;
      v1      <= valid_i;
      dout    <= d_flat;
      err_o   <= |err_q;
      valid_o <= v1;
    end
  end

endmodule

// File: tb/tb_coeff_recomposer.sv
// Bench for coeff_recomposer: directed table, backpressure/reset/gap sequences,
// decomposer round trips and random raw vectors against an arithmetic model.
module tb_coeff_recomposer;

  localparam int unsigned W  = 24;
  localparam int unsigned L  = 4;
  localparam int unsigned DW = W * L;
  localparam int          QI = 8380417;

  logic          clk = 1'b0;
  logic          rst;
  logic [2:0]    sec_lvl;
  logic          valid_i;
  logic          ready_i;
  logic [DW-1:0] dia;
  logic [DW-1:0] dib;
  logic [DW-1:0] dout;
  logic          valid_o;
  logic          ready_o;
  logic          err_o;

  coeff_recomposer #(.COEFF_W(W), .LANES(L)) dut (
    .clk(clk), .rst(rst), .sec_lvl(sec_lvl), .valid_i(valid_i), .ready_i(ready_i),
    .dia(dia), .dib(dib), .dout(dout), .valid_o(valid_o), .ready_o(ready_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic err; logic [DW-1:0] d; } exp_t;
  typedef struct { logic [2:0] sec; logic [DW-1:0] a; logic [DW-1:0] b; logic [DW-1:0] d; logic e; } tv_t;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  logic rand_bp = 1'b0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  function automatic logic [DW-1:0] pack4(input logic [W-1:0] a0, a1, a2, a3);
    return {a3, a2, a1, a0};
  endfunction

  function automatic int alpha_of(input logic [2:0] s);
    return (s == 3'd2) ? 190464 : 523776;
  endfunction

  // (r1*alpha mod 2^24 + r0), one conditional subtraction of q, kept to 24 bits
  function automatic logic [W-1:0] recomp(input logic [2:0] s, input logic [W-1:0] r1, input logic [W-1:0] r0);
    longint p, sm;
    p  = (longint'(r1) * longint'(alpha_of(s))) % 64'sd16777216;
    sm = p + longint'(r0);
    if (sm >= longint'(QI)) sm = sm - longint'(QI);
    return W'(sm);
  endfunction

  function automatic logic err_of(input logic [2:0] s, input logic [W-1:0] r1, input logic [W-1:0] r0);
    return (r1 > ((s == 3'd2) ? 24'd43 : 24'd15)) || (r0 >= 24'd8380417);
  endfunction

  function automatic exp_t model_beat(input logic [2:0] s, input logic [DW-1:0] a, input logic [DW-1:0] b);
    exp_t e;
    e = '0;
    for (int k = 0; k < int'(L); k++) begin
      e.d[k*W +: W] = recomp(s, a[k*W +: W], b[k*W +: W]);
      e.err = e.err | err_of(s, a[k*W +: W], b[k*W +: W]);
    end
    return e;
  endfunction

  // Reference decomposer: centred r0, with the q-1 wrap folded into r1=0
  task automatic decomp(input int r, input int alpha, output logic [W-1:0] r1, output logic [W-1:0] r0);
    int a0;
    a0 = r % alpha;
    if (a0 > alpha / 2) a0 = a0 - alpha;
    if (r - a0 == QI - 1) begin
      r1 = '0;
      a0 = a0 - 1;
    end else begin
      r1 = W'((r - a0) / alpha);
    end
    r0 = W'((a0 < 0) ? a0 + QI : a0);
  endtask

  // Scoreboard: every delivered beat must match the oldest expected entry
  always @(negedge clk) begin
    if (rst && valid_o && ready_o) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sb_unexpected: got beat %h expected none", dout);
      end else begin
        mon_e = exp_q.pop_front();
        chk("sb_data", dout, mon_e.d);
        chk("sb_err", DW'(err_o), DW'(mon_e.err));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_bp) ready_o = ($urandom_range(3) != 0);
  endtask

  task automatic send(input logic [2:0] s, input logic [DW-1:0] a, input logic [DW-1:0] b, input exp_t e);
    logic ok;
    sec_lvl = s;
    dia     = a;
    dib     = b;
    valid_i = 1'b1;
    ok      = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      ok = ready_i;
      step();
    end
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: got ready_i=0 for 200 cycles expected acceptance");
    end else begin
      exp_q.push_back(e);
    end
  endtask

  task automatic drain();
    valid_i = 1'b0;
    rand_bp = 1'b0;
    ready_o = 1'b1;
    for (int k = 0; k < 50 && exp_q.size() > 0; k++) step();
    step();
    step();
    chk("drain_empty", DW'(exp_q.size()), DW'(0));
  endtask

  function automatic logic [DW-1:0] rand_legal(input logic [2:0] s, input logic r0_side);
    logic [DW-1:0] v;
    for (int k = 0; k < int'(L); k++) begin
      if (r0_side) v[k*W +: W] = W'($urandom_range(QI - 1));
      else         v[k*W +: W] = W'($urandom_range((s == 3'd2) ? 43 : 15));
    end
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish by 1 ms expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tv_t           tv[8];
    exp_t          e;
    logic [2:0]    s;
    logic [DW-1:0] a, b;
    logic [DW-1:0] pa[3], pb[3];
    exp_t          pe[3];
    logic          pat[5];
    int            specials[6];
    logic [2:0]    secs[3];
    logic [W-1:0]  r1, r0;
    int            r;

    tv[0] = '{3'd2, pack4(24'd43, 24'd0, 24'd43, 24'd1), pack4(24'd0, 24'd0, 24'd8380416, 24'd8380416),
              pack4(24'd8189952, 24'd0, 24'd8189951, 24'd190463), 1'b0};
    tv[1] = '{3'd3, pack4(24'd15, 24'd15, 24'd0, 24'd3), pack4(24'd261888, 24'd8118530, 24'd0, 24'd5),
              pack4(24'd8118528, 24'd7594753, 24'd0, 24'd1571333), 1'b0};
    tv[2] = '{3'd3, pack4(24'd15, 24'd15, 24'd16, 24'd0), pack4(24'd261888, 24'd8118530, 24'd0, 24'd0),
              pack4(24'd8118528, 24'd7594753, 24'd8380416, 24'd0), 1'b1};
    tv[3] = '{3'd2, pack4(24'd44, 24'd0, 24'd0, 24'd0), pack4(24'd0, 24'd0, 24'd0, 24'd0),
              pack4(24'd8380416, 24'd0, 24'd0, 24'd0), 1'b1};
    tv[4] = '{3'd5, pack4(24'd1, 24'd2, 24'd0, 24'd0), pack4(24'd0, 24'd0, 24'd8380417, 24'd7),
              pack4(24'd523776, 24'd1047552, 24'd0, 24'd7), 1'b1};
    tv[5] = '{3'd2, pack4(24'hFFFFFF, 24'hFFFFFF, 24'd0, 24'd0), pack4(24'd0, 24'hFFFFFF, 24'd0, 24'd0),
              pack4(24'd8206335, 24'd8206334, 24'd0, 24'd0), 1'b1};
    tv[6] = '{3'd0, pack4(24'd15, 24'd0, 24'd0, 24'd0), pack4(24'd524641, 24'd0, 24'd0, 24'd8380416),
              pack4(24'd864, 24'd0, 24'd0, 24'd8380416), 1'b0};
    tv[7] = '{3'd3, pack4(24'd43, 24'd0, 24'd0, 24'd0), pack4(24'd0, 24'd0, 24'd0, 24'd0),
              pack4(24'd5745152, 24'd0, 24'd0, 24'd0), 1'b1};

    rst = 1'b0; valid_i = 1'b0; ready_o = 1'b1; sec_lvl = 3'd2; dia = '0; dib = '0;
    #12;
    chk("reset_valid_o", DW'(valid_o), DW'(0));
    chk("reset_err_o", DW'(err_o), DW'(0));
    chk("reset_dout", dout, '0);
    @(posedge clk);
    #1 rst = 1'b1;
    #1 chk("reset_ready_i", DW'(ready_i), DW'(1));

    // Directed table: one beat each, visible after two edges
    for (int i = 0; i < 8; i++) begin
      send(tv[i].sec, tv[i].a, tv[i].b, '{tv[i].e, tv[i].d});
      valid_i = 1'b0;
      step();
      chk($sformatf("tv%0d_valid", i), DW'(valid_o), DW'(1));
      chk($sformatf("tv%0d_dout", i), dout, tv[i].d);
      chk($sformatf("tv%0d_err", i), DW'(err_o), DW'(tv[i].e));
    end
    drain();

    // Backpressure: A, B, C with ready_o low, then released
    ready_o = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s     = 3'(i + 2);
      pa[i] = rand_legal(s, 1'b0);
      pb[i] = rand_legal(s, 1'b1);
      pe[i] = model_beat(s, pa[i], pb[i]);
    end
    sec_lvl = 3'd2; dia = pa[0]; dib = pb[0]; valid_i = 1'b1;
    chk("bp_ready_a", DW'(ready_i), DW'(1));
    step();
    exp_q.push_back(pe[0]);
    sec_lvl = 3'd3; dia = pa[1]; dib = pb[1];
    chk("bp_ready_b", DW'(ready_i), DW'(1));
    step();
    exp_q.push_back(pe[1]);
    sec_lvl = 3'd4; dia = pa[2]; dib = pb[2];
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("bp_hold_valid%0d", i), DW'(valid_o), DW'(1));
      chk($sformatf("bp_hold_dout%0d", i), dout, pe[0].d);
      chk($sformatf("bp_hold_ready%0d", i), DW'(ready_i), DW'(0));
      step();
    end
    ready_o = 1'b1;
    #1 chk("bp_release_ready", DW'(ready_i), DW'(1));
    exp_q.push_back(pe[2]);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("bp_out_valid%0d", i), DW'(valid_o), DW'(1));
      chk($sformatf("bp_out_dout%0d", i), dout, pe[i].d);
      step();
      valid_i = 1'b0;
    end
    drain();

    // Asynchronous reset while an erroring beat is held at the output
    ready_o = 1'b0;
    a = pack4(24'd50, 24'd7, 24'd0, 24'd0);
    b = pack4(24'd100, 24'd5, 24'd0, 24'd0);
    send(3'd2, a, b, model_beat(3'd2, a, b));
    valid_i = 1'b0;
    step();
    chk("rst_pre_valid", DW'(valid_o), DW'(1));
    chk("rst_pre_err", DW'(err_o), DW'(1));
    #2 rst = 1'b0;
    #1;
    chk("rst_async_valid", DW'(valid_o), DW'(0));
    chk("rst_async_err", DW'(err_o), DW'(0));
    chk("rst_async_dout", dout, '0);
    exp_q.delete();
    ready_o = 1'b1;
    step();
    rst = 1'b1;
    #1 chk("rst_release_ready", DW'(ready_i), DW'(1));
    a = pack4(24'd3, 24'd9, 24'd0, 24'd15);
    b = pack4(24'd11, 24'd8380416, 24'd0, 24'd1);
    e = model_beat(3'd3, a, b);
    send(3'd3, a, b, e);
    valid_i = 1'b0;
    chk("rst_new_early", DW'(valid_o), DW'(0));
    step();
    chk("rst_new_valid", DW'(valid_o), DW'(1));
    chk("rst_new_dout", dout, e.d);
    drain();

    // Sparse valid_i pattern 1,0,1,1,0 reappears two cycles later
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 7; i++) begin
      if (i < 5) begin
        s = 3'($urandom);
        a = rand_legal(s, 1'b0);
        b = rand_legal(s, 1'b1);
        sec_lvl = s; dia = a; dib = b; valid_i = pat[i];
        if (pat[i]) exp_q.push_back(model_beat(s, a, b));
      end else begin
        valid_i = 1'b0;
      end
      chk($sformatf("gap_valid%0d", i), DW'(valid_o), DW'((i >= 2) ? pat[i-2] : 1'b0));
      step();
    end
    drain();

    // Round trip through the reference decomposer at sec_lvl 2, 3 and 5
    specials = '{QI - 1, 0, 95232, 95233, 261888, 261889};
    secs     = '{3'd2, 3'd3, 3'd5};
    rand_bp  = 1'b1;
    for (int beat = 0; beat < 750; beat++) begin
      s = secs[beat % 3];
      for (int k = 0; k < int'(L); k++) begin
        r = ((beat / 3) * 4 + k < 6) ? specials[(beat / 3) * 4 + k] : int'($urandom_range(QI - 1));
        decomp(r, alpha_of(s), r1, r0);
        a[k*W +: W] = r1;
        b[k*W +: W] = r0;
        e.d[k*W +: W] = W'(r);
      end
      e.err = 1'b0;
      send(s, a, b, e);
      if ($urandom_range(3) == 0) begin
        valid_i = 1'b0;
        step();
      end
    end
    drain();

    // Random raw vectors, including out-of-range r1/r0
    rand_bp = 1'b1;
    for (int beat = 0; beat < 200; beat++) begin
      s = 3'($urandom);
      for (int k = 0; k < int'(L); k++) begin
        a[k*W +: W] = ($urandom_range(7) == 0) ? W'($urandom) : W'($urandom_range(47));
        b[k*W +: W] = ($urandom_range(7) == 0) ? W'($urandom) : W'($urandom_range(QI - 1));
      end
      send(s, a, b, model_beat(s, a, b));
      if ($urandom_range(4) == 0) begin
        valid_i = 1'b0;
        step();
      end
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/coeff_recomposer.md
Name: coeff_recomposer

Overview:
- Inverse of coeff_decomposer.
- Takes high-part/low-part coefficient pairs (r1, r0) and rebuilds r = (r1*alpha + r0) mod q, with alpha = 2*gamma2 selected by sec_lvl.
- Processes LANES coefficients per beat in a 2-stage valid/ready pipeline.
- Sits on the UseHint/verify path, feeding rebuilt w' coefficients into the packer, and serves as the bench-side check for coeff_decomposer round trips.

Parameters:
COEFF_W, 24, width of one coefficient field
LANES, 4, coefficients per beat

Ports:
clk  input  1  clock; all state on rising edge
rst  input  1  asynchronous, active-low reset (rst=0 resets immediately)
sec_lvl  input  3  security level: 3'd2 selects alpha=190464 (N1); any other value selects alpha=523776 (N2); sampled with each accepted beat
valid_i  input  1  input beat valid
ready_i  output  1  block can accept an input beat
dia  input  COEFF_W*LANES  r1 lanes; lane k at bits [k*COEFF_W +: COEFF_W]
dib  input  COEFF_W*LANES  r0 lanes, as mod-q representatives in [0, q-1]
do  output  COEFF_W*LANES  recomposed r lanes, each in [0, q-1]
valid_o  output  1  output beat valid
ready_o  input  1  downstream accepts the output beat
err_o  output  1  range error for the current output beat (qualified by valid_o)

Behaviour:
- Constants:
  - Q = 8380417.
  - N1 = 190464; r1 legal range 0..43.
  - N2 = 523776; r1 legal range 0..15.
- Handshake:
  - A beat is accepted when valid_i && ready_i.
  - A beat is delivered when valid_o && ready_o.
  - Global pipeline enable en = !valid_o || ready_o; ready_i = en (combinational).
  - While en=0, all pipeline registers hold. do, err_o and valid_o stay stable until delivered.
- Stage 1 (registered on en):
  - Per lane: p = r1 * alpha, computed as shift-add of constant alpha (no DSP inference required). p width 24 bits.
  - Also registered: r0; err1 = (r1 > limit for sec_lvl) || (r0 >= Q); v1 = valid_i.
- Stage 2 (registered on en):
  - s = p + r0, 25 bits.
  - do_lane = (s >= Q) ? s - Q : s.
  - Legal inputs give s < 2Q, so one conditional subtraction suffices.
  - Out-of-range lanes: do_lane is the 24-bit truncation of the same formula; no further reduction.
  - err_o = OR of err1 across lanes; valid_o = v1.
- Latency: with ready_o held 1, an input accepted at edge n appears with valid_o=1 after edge n+2. Throughput is 1 beat/cycle.
- Bubbles: invalid beats (v1=0) still advance when en=1. Consecutive accepted beats exit in order, none dropped or duplicated.
- Decomposer corner case: decomposer output (r1=0, r0=r-q) for r near q-1 recomposes to r via the mod-q formula; no special handling.
- Reset: rst=0 asynchronously clears v1, valid_o, err_o, do and all stage-1 data to 0. ready_i reads 1 (since valid_o=0) whenever rst=1 after reset. Reset mid-stream discards all in-flight beats.
- sec_lvl is captured per beat in stage 1. Changing it between beats affects only later beats.

Test Plan:
1. sec_lvl=2; lane0 r1=43, r0=0; lane1 r1=0, r0=0; lane2 r1=43, r0=8380416; lane3 r1=1, r0=8380416; ready_o=1 -> after 2 edges valid_o=1, do lanes = 8189952, 0, 8189951, 190463; err_o=0.
2. sec_lvl=3; lane0 r1=15, r0=261888; lane1 r1=15, r0=8118530 -> do = 8118528, 7594753; err_o=0. Lane2 r1=16 -> err_o=1 on that beat.
3. Backpressure: stream beats A, B, C with ready_o=0 -> ready_i drops once A reaches the output; do=A holds stable for 3 cycles. Raise ready_o -> A, B, C delivered on consecutive cycles, in order.
4. Reset mid-stream: assert rst=0 between clock edges while valid_o=1 -> valid_o, err_o and do go to 0 without a clock edge. Release rst -> ready_i=1; the first new beat emerges with latency 2.
5. Round trip: 1000 random r in [0, Q-1], including Q-1, 0, 95232, 95233, 261888, 261889. Run each through coeff_decomposer then coeff_recomposer at sec_lvl 2, 3 and 5 -> output equals r exactly; err_o never set.
6. Back-to-back with valid_i gaps: sparse valid_i pattern 1,0,1,1,0 -> valid_o pattern is the same sequence delayed by 2 cycles; payloads match.
